// File: rtl/reram_sched_pkg.sv
// Shared state encoding and command-word field positions for the
// ReRAM access scheduler.
package reram_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_ISSUE,
      WR_WAIT,
      RD_ISSUE,
      RESP
   } sched_state_t;

   localparam int ROW_MSB  = 29;
   localparam int ROW_LSB  = 25;
   localparam int COL_MSB  = 24;
   localparam int COL_LSB  = 20;
   localparam int DATA_MSB = 7;
   localparam int DATA_LSB = 0;

   localparam int QDEPTH_DEFAULT = 32;

   function automatic logic [31:0] mk_cmd(
      input logic [4:0] row,
      input logic [4:0] col,
      input logic [7:0] wdata
   );
      logic [31:0] w;
      w = '0;
      w[ROW_MSB:ROW_LSB]   = row;
      w[COL_MSB:COL_LSB]   = col;
      w[DATA_MSB:DATA_LSB] = wdata;
      return w;
   endfunction

endpackage

// File: rtl/reram_access_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector, pointer
// moves past the winner whenever the grant is consumed.
module reram_rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_i,
   input  logic [NUM_REQ-1:0]         req,
   input  logic                       advance,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

   localparam int IW = $clog2(NUM_REQ);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] j;

   // Scan from the farthest offset down so the requester nearest the
   // pointer is the last writer and therefore wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      j       = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         j = IW'((int'(ptr_q) + i) % NUM_REQ);
         if (req[j]) begin
            gnt     = '0;
            gnt[j]  = 1'b1;
            gnt_idx = j;
         end
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ptr_q <= '0;
      end else if (advance && |req) begin
         if (gnt_idx == IW'(NUM_REQ - 1))
            ptr_q <= '0;
         else
            ptr_q <= gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/reram_access_scheduler.sv
// Shares the ReRAM macro between NUM_REQ requesters, one command in flight.
// Optional ack watchdog enabled by defining RERAM_SCHED_TIMEOUT_EN.
module reram_access_scheduler
   import reram_sched_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int QDEPTH      = QDEPTH_DEFAULT,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic [NUM_REQ-1:0]     req_valid_i,
   input  logic [NUM_REQ-1:0]     req_we_i,
   input  logic [NUM_REQ*32-1:0]  req_data_i,
   output logic [NUM_REQ-1:0]     req_ready_o,
   output logic [NUM_REQ-1:0]     rsp_valid_o,
   output logic [31:0]            rsp_data_o,
   output logic                   rsp_err_o,
   output logic                   reram_en_o,
   output logic                   reram_r_wb_o,
   output logic [31:0]            reram_dat_o,
   input  logic [31:0]            reram_rdata_i,
   input  logic                   reram_ack_i,
   output logic [5:0]             occupancy_o,
   output logic                   busy_o,
   output logic                   reram_rst_n_o
);

   localparam int         IW    = $clog2(NUM_REQ);
   localparam logic [5:0] QFULL = 6'(QDEPTH);

   sched_state_t state_q, state_d;

   logic [NUM_REQ-1:0] gnt;
   logic [IW-1:0]      gnt_idx;
   logic [IW-1:0]      idx_q;
   logic               arb_adv;
   logic               sel_we;
   logic [31:0]        sel_data;
   logic               sel_ill;
   logic [31:0]        cmd_q;
   logic [7:0]         rdata_q;
   logic               err_q;
   logic [5:0]         occ_q;
   logic [NUM_REQ-1:0] ready_c;
   logic               grant_c;
   logic               wr_done;
   logic               rd_done;
   logic               tmo;
   logic               tmo_c;
   logic               unused_rdata;

   reram_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .req      (req_valid_i),
      .advance  (arb_adv),
      .gnt      (gnt),
      .gnt_idx  (gnt_idx)
   );

   always_comb begin
      sel_we   = 1'b0;
      sel_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt[k]) begin
            sel_we   = req_we_i[k];
            sel_data = req_data_i[k*32 +: 32];
         end
      end
   end

   // Writes into a full queue or reads from an empty one never reach the macro.
   assign sel_ill = sel_we ? (occ_q >= QFULL) : (occ_q == '0);

   assign grant_c = (state_q == IDLE) && (|req_valid_i);
   assign wr_done = (state_q == WR_WAIT) && reram_ack_i;
   assign rd_done = (state_q == RD_ISSUE) && reram_ack_i;
   assign tmo_c   = tmo && !reram_ack_i;

`ifdef RERAM_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] tmo_cnt_q;
   logic          waiting;

   assign waiting = (state_q == WR_WAIT) || (state_q == RD_ISSUE);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         tmo_cnt_q <= '0;
      end else if ((state_d != state_q) &&
                   ((state_d == WR_WAIT) || (state_d == RD_ISSUE))) begin
         tmo_cnt_q <= '0;
      end else if (waiting) begin
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
   end

   assign tmo = waiting && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;

   assign tmo = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      arb_adv      = 1'b0;
      ready_c      = '0;
      reram_en_o   = 1'b0;
      reram_r_wb_o = 1'b0;
      rsp_valid_o  = '0;
      unique case (state_q)
         IDLE: begin
            if (grant_c) begin
               arb_adv = 1'b1;
               ready_c = gnt;
               if (sel_ill)
                  state_d = RESP;
               else if (sel_we)
                  state_d = WR_ISSUE;
               else
                  state_d = RD_ISSUE;
            end
         end
         // A longer EN pulse would be taken by the macro as a second write.
         WR_ISSUE: begin
            reram_en_o = 1'b1;
            state_d    = WR_WAIT;
         end
         WR_WAIT: begin
            if (wr_done || tmo_c)
               state_d = RESP;
         end
         RD_ISSUE: begin
            reram_en_o   = 1'b1;
            reram_r_wb_o = 1'b1;
            if (rd_done || tmo_c)
               state_d = RESP;
         end
         RESP: begin
            rsp_valid_o[idx_q] = 1'b1;
            state_d            = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cmd_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         occ_q   <= '0;
      end else begin
         state_q <= state_d;
         unique case (1'b1)
            grant_c: begin
               idx_q   <= gnt_idx;
               cmd_q   <= sel_data;
               rdata_q <= '0;
               err_q   <= sel_ill;
            end
            wr_done: begin
               if (occ_q < QFULL)
                  occ_q <= occ_q + 1'b1;
            end
            rd_done: begin
               rdata_q <= reram_rdata_i[DATA_MSB:DATA_LSB];
               if (occ_q != '0)
                  occ_q <= occ_q - 1'b1;
            end
            tmo_c: begin
               err_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Mask grants while reset is held so no requester drops a command.
   assign req_ready_o   = wb_rst_i ? '0 : ready_c;
   assign rsp_data_o    = (state_q == RESP) ? {24'd0, rdata_q} : '0;
   assign rsp_err_o     = (state_q == RESP) && err_q;
   assign reram_dat_o   = cmd_q;
   assign occupancy_o   = occ_q;
   assign busy_o        = (state_q != IDLE);
   assign reram_rst_n_o = ~wb_rst_i;
   assign unused_rdata  = ^reram_rdata_i[31:8];

endmodule

// File: tb/tb_reram_access_scheduler.sv
// Directed bench for reram_access_scheduler with a behavioural macro model.
module tb_reram_access_scheduler;
   import reram_sched_pkg::*;

   localparam int NREQ   = 2;
   localparam int QD     = 32;
   localparam int TMO    = 128;
   localparam int WR_DLY = 2;
   localparam int RD_DLY = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid, req_we, req_ready, rsp_valid;
   logic [NREQ*32-1:0] req_data;
   logic [31:0]       rsp_data, dat, rdata;
   logic              rsp_err, en, r_wb, ack, busy, rst_n_m;
   logic [5:0]        occ;

   logic              rv [NREQ];
   logic              rw [NREQ];
   logic [31:0]       rd [NREQ];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always_comb begin
      req_valid = '0;
      req_we    = '0;
      req_data  = '0;
      for (int k = 0; k < NREQ; k++) begin
         req_valid[k]         = rv[k];
         req_we[k]            = rw[k];
         req_data[k*32 +: 32] = rd[k];
      end
   end

   reram_access_scheduler #(
      .NUM_REQ     (NREQ),
      .QDEPTH      (QD),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .wb_clk_i      (clk),
      .wb_rst_i      (rst),
      .req_valid_i   (req_valid),
      .req_we_i      (req_we),
      .req_data_i    (req_data),
      .req_ready_o   (req_ready),
      .rsp_valid_o   (rsp_valid),
      .rsp_data_o    (rsp_data),
      .rsp_err_o     (rsp_err),
      .reram_en_o    (en),
      .reram_r_wb_o  (r_wb),
      .reram_dat_o   (dat),
      .reram_rdata_i (rdata),
      .reram_ack_i   (ack),
      .occupancy_o   (occ),
      .busy_o        (busy),
      .reram_rst_n_o (rst_n_m)
   );

   // Macro model: starts on EN rise, queue of written bytes, read aborts on EN drop.
   logic       en_d, mbusy, mwr, hold_ack;
   int         mdly;
   logic [7:0] mq [$];
   logic [7:0] mb;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ack   <= 1'b0;
         rdata <= '0;
         mbusy <= 1'b0;
         mwr   <= 1'b0;
         mdly  <= 0;
         en_d  <= 1'b0;
         mq.delete();
      end else begin
         ack  <= 1'b0;
         en_d <= en;
         if (!mbusy) begin
            if (en && !en_d) begin
               mbusy <= 1'b1;
               mwr   <= !r_wb;
               mdly  <= r_wb ? RD_DLY : WR_DLY;
               if (!r_wb) mq.push_back(dat[7:0]);
            end
         end else if (!mwr && !en) begin
            mbusy <= 1'b0;
         end else if (hold_ack) begin
            mbusy <= 1'b1;
         end else if (mdly > 1) begin
            mdly <= mdly - 1;
         end else begin
            ack   <= 1'b1;
            mbusy <= 1'b0;
            if (!mwr) begin
               mb = mq.pop_front();
               rdata <= {24'hABCDEF, mb};
            end
         end
      end
   end

   int wr_en_cyc = 0;
   int en_cyc    = 0;
   always @(posedge clk) begin
      if (en && !r_wb) wr_en_cyc++;
      if (en) en_cyc++;
   end

   logic log_on = 1'b0;
   int   glog [$];
   always @(negedge clk) begin
      if (!rst && |req_ready) begin
         checks++;
         if ($countones(req_ready) != 1) begin
            errors++;
            $display("FAIL grant_onehot: ready=%b, required one-hot", req_ready);
         end
         if (log_on) glog.push_back(req_ready[1] ? 1 : 0);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
      end
   endtask

   task automatic issue(input int k, input bit we, input logic [31:0] d, output bit ok);
      int n;
      ok = 1'b1;
      @(negedge clk);
      rv[k] = 1'b1;
      rw[k] = we;
      rd[k] = d;
      #1;
      n = 0;
      while (!req_ready[k] && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!req_ready[k]) begin
         checks++;
         errors++;
         ok = 1'b0;
         $display("FAIL grant_timeout: req %0d got no ready, required within 100 cycles", k);
      end else begin
         @(posedge clk);
         #1;
      end
      rv[k] = 1'b0;
   endtask

   task automatic do_cmd(input int k, input bit we, input logic [31:0] d,
                         input bit e_err, input logic [7:0] e_byte, input string nm);
      int n;
      bit ok;
      issue(k, we, d, ok);
      if (ok) begin
         n = 0;
         while (!rsp_valid[k] && n < 200) begin
            @(negedge clk);
            n++;
         end
         if (!rsp_valid[k]) begin
            checks++;
            errors++;
            $display("FAIL %s_rsp_timeout: no rsp_valid, required within 200 cycles", nm);
         end else begin
            chk({nm, "_err"}, 32'(rsp_err), 32'(e_err));
            chk({nm, "_data"}, rsp_data, {24'd0, e_byte});
         end
      end
   endtask

   task automatic stream(input int k, input int cnt, input logic [7:0] base);
      int n;
      @(negedge clk);
      for (int i = 0; i < cnt; i++) begin
         rv[k] = 1'b1;
         rw[k] = 1'b1;
         rd[k] = mk_cmd(5'(i), 5'(k), base + 8'(i));
         #1;
         n = 0;
         while (!req_ready[k] && n < 100) begin
            @(negedge clk);
            #1;
            n++;
         end
         if (!req_ready[k]) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout: req %0d cmd %0d not granted", k, i);
         end
         @(posedge clk);
         #1;
      end
      rv[k] = 1'b0;
   endtask

   typedef struct {
      int          k;
      bit          we;
      logic [31:0] data;
      bit          e_err;
      logic [7:0]  e_byte;
      logic [5:0]  e_occ;
      int          d_wr;
      int          d_en;
   } vec_t;

   vec_t vt [6];

   initial begin
      int n, w0, e0, ecnt;
      logic [7:0] eb;

      vt[0] = '{0, 1'b0, mk_cmd(0, 0, 0),         1'b1, 8'h00, 6'd0, 0, 0};
      vt[1] = '{0, 1'b1, 32'h2230_00A5,           1'b0, 8'h00, 6'd1, 1, 1};
      vt[2] = '{1, 1'b1, mk_cmd(1, 2, 8'h3C),     1'b0, 8'h00, 6'd2, 1, 1};
      vt[3] = '{0, 1'b0, mk_cmd(17, 3, 0),        1'b0, 8'hA5, 6'd1, 0, -1};
      vt[4] = '{1, 1'b0, mk_cmd(1, 2, 0),         1'b0, 8'h3C, 6'd0, 0, -1};
      vt[5] = '{1, 1'b0, mk_cmd(1, 2, 0),         1'b1, 8'h00, 6'd0, 0, 0};

      hold_ack = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         rv[k] = 1'b0;
         rw[k] = 1'b0;
         rd[k] = '0;
      end
      rst   = 1'b1;
      rv[0] = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_en", 32'(en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_occ", 32'(occ), 32'd0);
      chk("rst_rsp", {rsp_data[29:0], rsp_valid}, 32'd0);
      chk("rst_macro_rst_n", 32'(rst_n_m), 32'd0);
      rv[0] = 1'b0;
      rst   = 1'b0;
      @(negedge clk);
      chk("macro_rst_n_run", 32'(rst_n_m), 32'd1);

      for (int i = 0; i < 6; i++) begin
         w0 = wr_en_cyc;
         e0 = en_cyc;
         do_cmd(vt[i].k, vt[i].we, vt[i].data, vt[i].e_err, vt[i].e_byte,
                $sformatf("vec%0d", i));
         chk($sformatf("vec%0d_occ", i), 32'(occ), 32'(vt[i].e_occ));
         chk($sformatf("vec%0d_wr_en", i), 32'(wr_en_cyc - w0), 32'(vt[i].d_wr));
         if (vt[i].d_en >= 0)
            chk($sformatf("vec%0d_en", i), 32'(en_cyc - e0), 32'(vt[i].d_en));
      end

      log_on = 1'b1;
      fork
         stream(0, 4, 8'h10);
         stream(1, 4, 8'h20);
      join
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      log_on = 1'b0;
      chk("rr_count", 32'(glog.size()), 32'd8);
      for (int i = 0; i < glog.size(); i++)
         chk($sformatf("rr_grant%0d", i), 32'(glog[i]), 32'(i % 2));
      chk("rr_occ", 32'(occ), 32'd8);
      for (int j = 0; j < 8; j++) begin
         eb = ((j % 2) != 0 ? 8'h20 : 8'h10) + 8'(j / 2);
         do_cmd(0, 1'b0, '0, 1'b0, eb, $sformatf("rr_rd%0d", j));
      end
      chk("rr_drain_occ", 32'(occ), 32'd0);

      for (int i = 0; i < QD; i++)
         do_cmd(0, 1'b1, mk_cmd(5'(i), 5'(31 - i), 8'(i * 7 + 3)), 1'b0, 8'h00,
                $sformatf("fill%0d", i));
      chk("full_occ", 32'(occ), 32'(QD));
      e0 = en_cyc;
      do_cmd(0, 1'b1, mk_cmd(0, 0, 8'hEE), 1'b1, 8'h00, "overflow");
      chk("overflow_occ", 32'(occ), 32'(QD));
      chk("overflow_no_en", 32'(en_cyc - e0), 32'd0);
      for (int i = 0; i < QD; i++)
         do_cmd(i % 2, 1'b0, '0, 1'b0, 8'(i * 7 + 3), $sformatf("empty%0d", i));
      chk("empty_occ", 32'(occ), 32'd0);

      do_cmd(0, 1'b1, mk_cmd(2, 2, 8'h77), 1'b0, 8'h00, "pre_rst_wr");
      hold_ack = 1'b1;
      begin
         bit ok;
         issue(0, 1'b0, '0, ok);
      end
      repeat (10) @(negedge clk);
      chk("midrd_en_held", {30'd0, en, r_wb}, 32'd3);
      #2;
      rst = 1'b1;
      #1;
      chk("midrd_en_drop", 32'(en), 32'd0);
      chk("midrd_busy", 32'(busy), 32'd0);
      chk("midrd_occ", 32'(occ), 32'd0);
      ecnt = 0;
      repeat (2) begin
         @(negedge clk);
         if (rsp_valid != '0) ecnt++;
      end
      rst      = 1'b0;
      hold_ack = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid != '0) ecnt++;
      end
      chk("midrd_no_rsp", 32'(ecnt), 32'd0);
      chk("midrd_idle", 32'(busy), 32'd0);

`ifdef RERAM_SCHED_TIMEOUT_EN
      do_cmd(0, 1'b1, mk_cmd(3, 3, 8'h5A), 1'b0, 8'h00, "tmo_wr");
      hold_ack = 1'b1;
      begin
         bit ok;
         issue(0, 1'b0, '0, ok);
      end
      ecnt = 0;
      n    = 0;
      while (!rsp_valid[0] && n < TMO + 50) begin
         @(negedge clk);
         if (en) ecnt++;
         n++;
      end
      chk("tmo_en_cycles", 32'(ecnt), 32'(TMO));
      chk("tmo_rsp", {30'd0, rsp_valid[0], rsp_err}, 32'd3);
      chk("tmo_en_low", 32'(en), 32'd0);
      chk("tmo_data", rsp_data, 32'd0);
      chk("tmo_occ", 32'(occ), 32'd1);
      hold_ack = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, required finish before 500000");
      $fatal(1);
   end

endmodule
